ecc_enc_dec_core: RTL
=====================

# ecc_enc_dec_core

Sequenced extended-Hamming (SECDED) encode/decode engine that consumes the register outputs of the APB register bank (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE, start). The engine runs one of three operations per start pulse: encode, decode, or full channel (encode, inject noise, decode). It returns the result word, an error count and a one-cycle completion pulse. It sits directly downstream of the APB register bank.

## Interface
- AMBA_WORD, 32, width of all register-sourced data inputs and of data_out
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- CTRL  input  AMBA_WORD  operation select; only [1:0] are used: 0 encode, 1 decode, 2 full channel, 3 illegal
- DATA_IN  input  AMBA_WORD  data word (encode/full) or codeword (decode)
- CODEWORD_WIDTH  input  AMBA_WORD  only [1:0] are used: 0 → W=8, 1 → W=16, 2 → W=32, 3 illegal
- NOISE  input  AMBA_WORD  error mask XORed onto the codeword in full-channel mode; bits [W-1:0] are used
- start  input  1  one-cycle request pulse from the register bank
- data_out  output  AMBA_WORD  result, zero-extended
- operation_done  output  1  one-cycle completion pulse
- num_of_errors  output  2  0 none, 1 corrected, 2 detected/uncorrectable, 3 illegal request
- busy  output  1  high whenever the state is not IDLE

## Operation
- Code sizes: W=8/16/32 gives K=4/11/26 data bits and P=4/5/6 parity bits.
- Hamming positions 1..W-1:
  - Data bits d[0..K-1] fill the non-power-of-two positions in ascending order.
  - Parity p[j] (j=0..P-2) is the XOR of all positions whose index has bit j set.
  - p[P-1] is the XOR of positions 1..W-1, so the full W-bit word has even parity.
- Codeword layout is systematic: {p[P-1:0], d[K-1:0]} occupies bits [W-1:0]; bits above W-1 are 0.
- Input bits above W-1 (K-1 for data) are ignored.
- Decode:
  - s = recomputed p[P-2:0] XOR received p[P-2:0].
  - op = XOR of all W received bits.
  - s=0, op=0 → 0 errors.
  - op=1 → 1 error. If s addresses a data position, flip that bit; otherwise the data is unchanged.
  - s≠0, op=0 → 2 errors; data is returned uncorrected.
  - Decode and full-channel data_out = the K data bits, zero-extended.
- Encode data_out = the codeword; num_of_errors = 0.
- Illegal request (CTRL[1:0]=3 or CODEWORD_WIDTH[1:0]=3): data_out = 0, num_of_errors = 3.
- FSM states: IDLE, ENCODE, CHANNEL, SYNDROME, CORRECT, DONE.
  - IDLE + start: latch CTRL[1:0], width, DATA_IN and NOISE into internal registers. Next state: encode/full → ENCODE; decode → SYNDROME with work word = DATA_IN; illegal → DONE, with outputs loaded at the same time.
  - ENCODE: work word ← codeword. Next state: encode → DONE (outputs loaded); full → CHANNEL.
  - CHANNEL: work word ← work word ^ NOISE[W-1:0]. Next state: SYNDROME.
  - SYNDROME: register s and op. Next state: CORRECT.
  - CORRECT: load data_out and num_of_errors. Next state: DONE.
  - DONE: operation_done = 1. Next state: IDLE.
- start is ignored whenever the state is not IDLE. Register-bank inputs may change after the latch with no effect on the operation in flight.
- data_out and num_of_errors hold their values until the next operation completes.

## Timing
- Reset values: state IDLE, data_out = 0, num_of_errors = 0, operation_done = 0, busy = 0, all internal registers 0.
- Reset is effective immediately and asynchronously.
- Latency is counted from the clock edge that samples start to the cycle in which operation_done is high:
  - illegal: 1
  - encode: 2
  - decode: 3
  - full channel: 5
- operation_done is high for exactly one cycle. data_out and num_of_errors are valid in that same cycle.
- busy rises in the cycle after start is sampled and falls in the cycle after DONE.
- Earliest next accepted start: the cycle after operation_done (state IDLE).
- A start that coincides with DONE is dropped.
- Reset mid-operation aborts the operation with no operation_done pulse. Outputs return to 0.

## Test plan
- Encode: W=8, DATA_IN=0xB, start → after 2 cycles, operation_done=1, data_out=0x1B, num_of_errors=0.
- Decode: W=8, DATA_IN=0x1B → after 3 cycles, data_out=0xB, num_of_errors=0.
- Full channel: W=8, DATA_IN=0xB.
  - NOISE=0x04 → after 5 cycles, data_out=0xB, num_of_errors=1.
  - NOISE=0x80 → data_out=0xB, num_of_errors=1.
  - NOISE=0x03 → data_out=0x8, num_of_errors=2.
- W=16 and W=32 checks:
  - Encode random data, decode the result → original data, num_of_errors=0.
  - Full channel, every single-bit NOISE → original data, num_of_errors=1.
  - Full channel, every two-bit NOISE pair → num_of_errors=2.
  - DATA_IN bits above K-1 set → ignored.
- Illegal and collision:
  - CTRL=3 → operation_done 1 cycle after start, data_out=0, num_of_errors=3.
  - start pulsed while busy → no second operation_done.
- Reset: assert rst in CHANNEL state during full channel → outputs 0 immediately, no operation_done. A new start after reset completes normally.

Source files
------------

// File: rtl/ecc_enc_dec_core.sv
// ecc_enc_dec_core: sequenced extended-Hamming (SECDED) engine for 8/16/32-bit
// codewords. One start pulse runs encode, decode, or full channel
// (encode, XOR noise, decode). It returns the result word, an error
// classification and a one-cycle completion pulse.
module ecc_enc_dec_core #(
    parameter int AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    input  logic                 start,
    output logic [AMBA_WORD-1:0] data_out,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENCODE,
        S_CHANNEL,
        S_SYNDROME,
        S_CORRECT,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_ENCODE  = 2'd0;
    localparam logic [1:0] OP_DECODE  = 2'd1;
    localparam logic [1:0] OP_CHANNEL = 2'd2;

    state_t      r_state;
    logic [1:0]  r_opSel;
    logic [1:0]  r_widthSel;
    logic [25:0] r_dataIn;
    logic [31:0] r_noise;
    logic [31:0] r_work;
    logic [4:0]  r_syndrome;
    logic        r_overall;

    logic [25:0] w_kMask;
    logic [31:0] w_wMask;
    logic [25:0] w_encData;
    logic [31:0] w_encHam;
    logic [4:0]  w_encPar;
    logic [31:0] w_codeword;
    logic [25:0] w_rxData;
    logic [4:0]  w_rxPar;
    logic [31:0] w_rxHam;
    logic [4:0]  w_rxCalcPar;
    logic [4:0]  w_syndrome;
    logic        w_overall;
    logic [31:0] w_corrHam;
    logic [25:0] w_corrData;
    logic [1:0]  w_corrErrors;
    logic        w_startIllegal;
    logic        w_unused;

    // Places data bits onto the non-power-of-two Hamming positions in
    // ascending order. The order is the same for every width, so a narrower
    // code is simply the same mapping with the upper data bits masked off.
    function automatic logic [31:0] f_scatter(input logic [25:0] d);
        logic [31:0] h;
        logic [4:0]  k;
        h = '0;
        k = '0;
        for (int i = 1; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                h[i] = d[k];
                k = k + 5'd1;
            end
        end
        return h;
    endfunction

    // Inverse of f_scatter: collects the data positions back into a dense word.
    function automatic logic [25:0] f_gather(input logic [31:0] h);
        logic [25:0] d;
        logic [4:0]  k;
        d = '0;
        k = '0;
        for (int i = 1; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = h[i];
                k = k + 5'd1;
            end
        end
        return d;
    endfunction

    // Parity j covers every position whose index has bit j set; positions
    // beyond the active width are zero in h, so they never contribute.
    function automatic logic [4:0] f_parity(input logic [31:0] h);
        return {^(h & 32'hFFFF_0000), ^(h & 32'hFF00_FF00),
                ^(h & 32'hF0F0_F0F0), ^(h & 32'hCCCC_CCCC),
                ^(h & 32'hAAAA_AAAA)};
    endfunction

    assign busy           = (r_state != S_IDLE);
    assign w_startIllegal = (CTRL[1:0] == 2'd3) || (CODEWORD_WIDTH[1:0] == 2'd3);
    assign w_unused       = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

    // Data-bit and codeword-bit masks for the latched width.
    always_comb begin
        w_kMask = 26'h3FF_FFFF;
        w_wMask = 32'hFFFF_FFFF;
        case (r_widthSel)
            2'd0: begin
                w_kMask = 26'h000_000F;
                w_wMask = 32'h0000_00FF;
            end
            2'd1: begin
                w_kMask = 26'h000_07FF;
                w_wMask = 32'h0000_FFFF;
            end
            default: begin
            end
        endcase
    end

    // Encoder: systematic {overall, parity, data}, overall parity in bit W-1.
    always_comb begin
        w_encData = r_dataIn & w_kMask;
        w_encHam  = f_scatter(w_encData);
        w_encPar  = f_parity(w_encHam);
        case (r_widthSel)
            2'd0:    w_codeword = {24'd0, ^{w_encData[3:0], w_encPar[2:0]},
                                   w_encPar[2:0], w_encData[3:0]};
            2'd1:    w_codeword = {16'd0, ^{w_encData[10:0], w_encPar[3:0]},
                                   w_encPar[3:0], w_encData[10:0]};
            default: w_codeword = {^{w_encData, w_encPar}, w_encPar, w_encData};
        endcase
    end

    // Syndrome path: split the work word into data and Hamming parity, then
    // compare received parity with parity recomputed from the received data.
    always_comb begin
        case (r_widthSel)
            2'd0: begin
                w_rxData = {22'd0, r_work[3:0]};
                w_rxPar  = {2'd0, r_work[6:4]};
            end
            2'd1: begin
                w_rxData = {15'd0, r_work[10:0]};
                w_rxPar  = {1'b0, r_work[14:11]};
            end
            default: begin
                w_rxData = r_work[25:0];
                w_rxPar  = r_work[30:26];
            end
        endcase
        w_rxHam     = f_scatter(w_rxData);
        w_rxCalcPar = f_parity(w_rxHam);
        w_syndrome  = w_rxCalcPar ^ w_rxPar;
        w_overall   = ^(r_work & w_wMask);
    end

    // Correction: an odd overall parity means one error, flipped only when the
    // syndrome points at a data position (parity-bit hits leave data alone).
    always_comb begin
        w_corrHam    = w_rxHam;
        w_corrErrors = 2'd0;
        if (r_overall) begin
            w_corrErrors = 2'd1;
            if ((r_syndrome != 5'd0) && ((r_syndrome & (r_syndrome - 5'd1)) != 5'd0)) begin
                w_corrHam[r_syndrome] = ~w_corrHam[r_syndrome];
            end
        end else if (r_syndrome != 5'd0) begin
            w_corrErrors = 2'd2;
        end
        w_corrData = f_gather(w_corrHam) & w_kMask;
    end

    // Operation sequencer; results and the done pulse are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_opSel        <= 2'd0;
            r_widthSel     <= 2'd0;
            r_dataIn       <= '0;
            r_noise        <= '0;
            r_work         <= '0;
            r_syndrome     <= '0;
            r_overall      <= 1'b0;
            data_out       <= '0;
            num_of_errors  <= 2'd0;
            operation_done <= 1'b0;
        end else begin
            operation_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opSel    <= CTRL[1:0];
                        r_widthSel <= CODEWORD_WIDTH[1:0];
                        r_dataIn   <= DATA_IN[25:0];
                        r_noise    <= NOISE;
                        if (w_startIllegal) begin
                            data_out       <= '0;
                            num_of_errors  <= 2'd3;
                            operation_done <= 1'b1;
                            r_state        <= S_DONE;
                        end else if (CTRL[1:0] == OP_DECODE) begin
                            r_work  <= DATA_IN;
                            r_state <= S_SYNDROME;
                        end else begin
                            r_state <= S_ENCODE;
                        end
                    end
                end
                S_ENCODE: begin
                    r_work <= w_codeword;
                    if (r_opSel == OP_CHANNEL) begin
                        r_state <= S_CHANNEL;
                    end else begin
                        data_out       <= w_codeword;
                        num_of_errors  <= 2'd0;
                        operation_done <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_CHANNEL: begin
                    r_work  <= r_work ^ (r_noise & w_wMask);
                    r_state <= S_SYNDROME;
                end
                S_SYNDROME: begin
                    r_syndrome <= w_syndrome;
                    r_overall  <= w_overall;
                    r_state    <= S_CORRECT;
                end
                S_CORRECT: begin
                    data_out       <= {6'd0, w_corrData};
                    num_of_errors  <= w_corrErrors;
                    operation_done <= 1'b1;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
